uart_rx_fifo: RTL

UART receiver with an integrated receive FIFO. It is the receive-side counterpart of the existing UART transmitter in the peripherals block, and uses the same baud-period and stable-time conventions.
It deserialises 8N1 frames from RXD and pushes good bytes into a FIFO. Software pops bytes through the peripherals register interface via fifo_read_req. Status flags feed the RX status register and the interrupt source register.

---
 rtl/uart_rx_fifo.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
//------------------------------------------------------------------------------
// uart_rx_fifo
//
// UART receiver (8N1, LSB first) with an integrated receive FIFO. Serial
// frames arriving on RXD are deserialised and good bytes are pushed into the
// FIFO. Software pops bytes one at a time through fifo_read_req. The status
// flags feed the RX status register and the interrupt source register.
//
// Ports:
//   clk                  clock
//   reset_n              asynchronous active-low reset
//   sync_reset           synchronous reset, same effect as reset_n
//   baud_rate_period_m1  clk cycles per bit minus 1 (static during a frame)
//   RXD                  asynchronous serial input, idle high
//   fifo_read_req        single-cycle pop request
//   enable_out           one-cycle pulse: data_out was updated by a pop
//   data_out             last popped byte
//   fifo_full            FIFO holds 2^FIFO_DEPTH_BITS entries
//   fifo_not_empty       FIFO holds at least one entry
//   framing_error        one-cycle pulse: stop bit sampled low
//   overrun              sticky: a byte was dropped because the FIFO was full
//------------------------------------------------------------------------------
module uart_rx_fifo #(
   parameter int STABLE_TIME      = 15,
   parameter int BAUD_PERIOD_BITS = 16,
   parameter int DATA_BITS        = 8,
   parameter int FIFO_DEPTH_BITS  = 3
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        sync_reset,
   input  logic [BAUD_PERIOD_BITS-1:0] baud_rate_period_m1,
   input  logic                        RXD,
   input  logic                        fifo_read_req,
   output logic                        enable_out,
   output logic [DATA_BITS-1:0]        data_out,
   output logic                        fifo_full,
   output logic                        fifo_not_empty,
   output logic                        framing_error,
   output logic                        overrun
);

   localparam int DEPTH    = 1 << FIFO_DEPTH_BITS;
   localparam int STABLE_W = $clog2(STABLE_TIME + 1);
   localparam int IDX_W    = $clog2(DATA_BITS + 1);
   localparam int CNT_W    = FIFO_DEPTH_BITS + 1;

   typedef enum logic [2:0] {
      WAIT_STABLE,
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   //---------------------------------------------------------------------------
   // Input synchroniser. Both flops reset to 1 so the line looks idle.
   //---------------------------------------------------------------------------
   logic rxd_meta;
   logic rxd_s;

   // NOTE: sequential state is always written with non-blocking assignments so
   // every flop samples the pre-edge value of every other flop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rxd_meta <= 1'b1;
         rxd_s    <= 1'b1;
      end else if (sync_reset) begin
         rxd_meta <= 1'b1;
         rxd_s    <= 1'b1;
      end else begin
         rxd_meta <= RXD;
         rxd_s    <= rxd_meta;
      end
   end

   //---------------------------------------------------------------------------
   // Bit timing. The timer is loaded with (period - 1) and expires when it
   // reads zero, so a load of H-1 expires H cycles after the load edge.
   // The period is computed one bit wider so m1 = all-ones cannot wrap.
   //---------------------------------------------------------------------------
   logic [BAUD_PERIOD_BITS:0]   period;
   logic [BAUD_PERIOD_BITS-1:0] half;
   logic [BAUD_PERIOD_BITS-1:0] half_m1;

   assign period  = {1'b0, baud_rate_period_m1} + 1'b1;
   assign half    = BAUD_PERIOD_BITS'(period >> 1);
   assign half_m1 = (half == '0) ? '0 : half - 1'b1;

   //---------------------------------------------------------------------------
   // Receive FSM
   //---------------------------------------------------------------------------
   state_t                      state;
   logic [STABLE_W-1:0]         stable_cnt;
   logic [BAUD_PERIOD_BITS-1:0] timer;
   logic [IDX_W-1:0]            bit_idx;
   logic [DATA_BITS-1:0]        shift_reg;
   logic                        push_req;
   logic                        timer_done;

   assign timer_done = (timer == '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= WAIT_STABLE;
         stable_cnt    <= '0;
         timer         <= '0;
         bit_idx       <= '0;
         shift_reg     <= '0;
         push_req      <= 1'b0;
         framing_error <= 1'b0;
      end else if (sync_reset) begin
         state         <= WAIT_STABLE;
         stable_cnt    <= '0;
         timer         <= '0;
         bit_idx       <= '0;
         shift_reg     <= '0;
         push_req      <= 1'b0;
         framing_error <= 1'b0;
      end else begin
         // Single-cycle strobes; only the stop-bit sample raises them.
         push_req      <= 1'b0;
         framing_error <= 1'b0;

         case (state)
            WAIT_STABLE: begin
               if (!rxd_s) begin
                  stable_cnt <= '0;
               end else if (stable_cnt == STABLE_W'(STABLE_TIME - 1)) begin
                  stable_cnt <= '0;
                  state      <= IDLE;
               end else begin
                  stable_cnt <= stable_cnt + 1'b1;
               end
            end

            IDLE: begin
               if (!rxd_s) begin
                  timer <= half_m1;
                  state <= START;
               end
            end

            START: begin
               if (timer_done) begin
                  if (rxd_s) begin
                     // Line back high at mid start bit: a glitch, not a frame.
                     state <= IDLE;
                  end else begin
                     timer   <= baud_rate_period_m1;
                     bit_idx <= '0;
                     state   <= DATA;
                  end
               end else begin
                  timer <= timer - 1'b1;
               end
            end

            DATA: begin
               if (timer_done) begin
                  // LSB arrives first, so each new bit enters at the MSB and
                  // the first bit ends up in bit 0 after DATA_BITS shifts.
                  shift_reg <= {rxd_s, shift_reg[DATA_BITS-1:1]};
                  timer     <= baud_rate_period_m1;
                  if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  timer <= timer - 1'b1;
               end
            end

            STOP: begin
               if (timer_done) begin
                  if (rxd_s) begin
                     push_req <= 1'b1;
                     state    <= IDLE;
                  end else begin
                     framing_error <= 1'b1;
                     stable_cnt    <= '0;
                     state         <= WAIT_STABLE;
                  end
               end else begin
                  timer <= timer - 1'b1;
               end
            end

            default: begin
               state <= WAIT_STABLE;
            end
         endcase
      end
   end

   //---------------------------------------------------------------------------
   // Receive FIFO. Occupancy is tracked by a counter one bit wider than the
   // pointers so that full and empty are distinguishable. Flags are registered
   // from the next-state occupancy, so they change on the same edge as it.
   //---------------------------------------------------------------------------
   logic [DATA_BITS-1:0]       mem [DEPTH];
   logic [FIFO_DEPTH_BITS-1:0] wr_ptr;
   logic [FIFO_DEPTH_BITS-1:0] rd_ptr;
   logic [CNT_W-1:0]           count;
   logic [CNT_W-1:0]           count_next;
   logic                       pop;
   logic                       push;

   // A pop on an empty FIFO is ignored; a pop on a full FIFO frees the slot
   // that a simultaneous push then takes.
   assign pop  = fifo_read_req && fifo_not_empty;
   assign push = push_req && (!fifo_full || pop);

   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      count_next = count;
      if (push && !pop) begin
         count_next = count + 1'b1;
      end else if (pop && !push) begin
         count_next = count - 1'b1;
      end
   end

   // NOTE: the storage array has no reset; occupancy and pointers alone define
   // which entries are valid, so stale contents are never observable.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= shift_reg;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         fifo_full      <= 1'b0;
         fifo_not_empty <= 1'b0;
         overrun        <= 1'b0;
         enable_out     <= 1'b0;
         data_out       <= '0;
      end else if (sync_reset) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         fifo_full      <= 1'b0;
         fifo_not_empty <= 1'b0;
         overrun        <= 1'b0;
         enable_out     <= 1'b0;
         data_out       <= '0;
      end else begin
         count          <= count_next;
         fifo_full      <= (count_next == CNT_W'(DEPTH));
         fifo_not_empty <= (count_next != '0);
         enable_out     <= pop;

         if (push) begin
            wr_ptr <= wr_ptr + FIFO_DEPTH_BITS'(1);
         end

         if (pop) begin
            data_out <= mem[rd_ptr];
            rd_ptr   <= rd_ptr + FIFO_DEPTH_BITS'(1);
         end

         if (push_req && !push) begin
            overrun <= 1'b1;
         end
      end
   end

endmodule
